// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: mic bit clock generation, 2-flop input sync,
// 3rd-order CIC decimator to signed 16-bit PCM with a one-cycle strobe.
// Ports: clk, rst (async high), en (run/clear), mic_data (async PDM in),
//        mic_clk (registered bit clock), pcm_data[15:0], pcm_valid.
`timescale 1ns/1ps
module pdm_mic_rx #(
  parameter int CLK_DIV      = 10,
  parameter int DECIM_LOG2   = 6,
  parameter int CAPTURE_RISE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mic_data,
  output logic        mic_clk,
  output logic [15:0] pcm_data,
  output logic        pcm_valid
);

  localparam int W     = 3 * DECIM_LOG2 + 2;
  localparam int DW    = $clog2(CLK_DIV);
  localparam int SHIFT = 3 * DECIM_LOG2 - 15;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [DECIM_LOG2-1:0] BIT_MAX = '1;

  localparam logic signed [W-1:0] PLUS1   = W'(1);
  localparam logic signed [W-1:0] MINUS1  = '1;
  localparam logic signed [W-1:0] PCM_MAX = W'(32767);
  localparam logic signed [W-1:0] PCM_MIN = W'(-32768);

  logic                  run_q, run_d;
  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic                  mclk_q, mclk_d;
  logic                  cap_q, cap_d;
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic [DECIM_LOG2-1:0] bcnt_q, bcnt_d;
  logic signed [W-1:0]   i1_q, i1_d;
  logic signed [W-1:0]   i2_q, i2_d;
  logic signed [W-1:0]   i3_q, i3_d;
  logic signed [W-1:0]   c0_q, c0_d;
  logic signed [W-1:0]   d1_q, d1_d;
  logic signed [W-1:0]   y1_q, y1_d;
  logic signed [W-1:0]   d2_q, d2_d;
  logic signed [W-1:0]   y2_q, y2_d;
  logic signed [W-1:0]   d3_q, d3_d;
  logic                  f0_q, f0_d;
  logic                  f1_q, f1_d;
  logic                  f2_q, f2_d;
  logic [1:0]            settle_q, settle_d;
  logic [15:0]           pcm_q, pcm_d;
  logic                  vld_q, vld_d;

  logic signed [W-1:0]   x;
  logic signed [W-1:0]   diff3;
  logic signed [W-1:0]   shr;

  always_comb begin
    x     = s2_q ? PLUS1 : MINUS1;
    diff3 = y2_q - d3_q;
    shr   = diff3 >>> SHIFT;

    run_d     = en;
    div_cnt_d = div_cnt_q;
    mclk_d    = mclk_q;
    cap_d     = 1'b0;
    // Sync runs whenever en is high so it is already primed
    // by the first mic_clk edge.
    s1_d      = mic_data;
    s2_d      = s1_q;
    bcnt_d    = bcnt_q;
    i1_d      = i1_q;
    i2_d      = i2_q;
    i3_d      = i3_q;
    c0_d      = c0_q;
    d1_d      = d1_q;
    y1_d      = y1_q;
    d2_d      = d2_q;
    y2_d      = y2_q;
    d3_d      = d3_q;
    f0_d      = 1'b0;
    f1_d      = f0_q;
    f2_d      = f1_q;
    settle_d  = settle_q;
    pcm_d     = pcm_q;
    vld_d     = 1'b0;

    if (en && run_q) begin
      div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + 1'b1;
      if (div_cnt_q == '0) begin
        mclk_d = 1'b1;
      end else if (div_cnt_q == DIV_HALF) begin
        mclk_d = 1'b0;
      end
      // Strobe is registered alongside mic_clk, so it is high in
      // the cycle mic_clk shows the capture edge.
      if (CAPTURE_RISE != 0) begin
        cap_d = (div_cnt_q == '0);
      end else begin
        cap_d = (div_cnt_q == DIV_HALF);
      end

      if (cap_q) begin
        i1_d   = i1_q + x;
        i2_d   = i2_q + i1_q;
        i3_d   = i3_q + i2_q;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == BIT_MAX) begin
          f0_d = 1'b1;
          c0_d = i3_q + i2_q;
        end
      end

      if (f0_q) begin
        y1_d = c0_q - d1_q;
        d1_d = c0_q;
      end
      if (f1_q) begin
        y2_d = y1_q - d2_q;
        d2_d = y1_q;
      end
      if (f2_q) begin
        d3_d = y2_q;
        if (shr > PCM_MAX) begin
          pcm_d = PCM_MAX[15:0];
        end else if (shr < PCM_MIN) begin
          pcm_d = PCM_MIN[15:0];
        end else begin
          pcm_d = shr[15:0];
        end
        // First three frames only fill the comb delay line.
        if (settle_q == 2'd3) begin
          vld_d = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
    end

    if (!en) begin
      run_d     = 1'b0;
      div_cnt_d = '0;
      mclk_d    = 1'b0;
      cap_d     = 1'b0;
      s1_d      = 1'b0;
      s2_d      = 1'b0;
      bcnt_d    = '0;
      i1_d      = '0;
      i2_d      = '0;
      i3_d      = '0;
      c0_d      = '0;
      d1_d      = '0;
      y1_d      = '0;
      d2_d      = '0;
      y2_d      = '0;
      d3_d      = '0;
      f0_d      = 1'b0;
      f1_d      = 1'b0;
      f2_d      = 1'b0;
      settle_d  = '0;
      pcm_d     = '0;
      vld_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q     <= 1'b0;
      div_cnt_q <= '0;
      mclk_q    <= 1'b0;
      cap_q     <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      bcnt_q    <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      c0_q      <= '0;
      d1_q      <= '0;
      y1_q      <= '0;
      d2_q      <= '0;
      y2_q      <= '0;
      d3_q      <= '0;
      f0_q      <= 1'b0;
      f1_q      <= 1'b0;
      f2_q      <= 1'b0;
      settle_q  <= '0;
      pcm_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      run_q     <= run_d;
      div_cnt_q <= div_cnt_d;
      mclk_q    <= mclk_d;
      cap_q     <= cap_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      bcnt_q    <= bcnt_d;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      c0_q      <= c0_d;
      d1_q      <= d1_d;
      y1_q      <= y1_d;
      d2_q      <= d2_d;
      y2_q      <= y2_d;
      d3_q      <= d3_d;
      f0_q      <= f0_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      settle_q  <= settle_d;
      pcm_q     <= pcm_d;
      vld_q     <= vld_d;
    end
  end

  assign mic_clk   = mclk_q;
  assign pcm_data  = pcm_q;
  assign pcm_valid = vld_q;

endmodule
